key4_debounce: RTL and testbench
================================

# key4_debounce

Four-channel pushbutton input conditioner for the motor-control board: the input-side counterpart of the 4-LED status driver. It synchronises four raw, bouncing, active-low key lines and debounces each one with a shared millisecond tick. It publishes clean levels, one-cycle press/release pulses and an encoded key event to the control logic. An optional long-press detector can be compiled in.

## Interface
- `TICK_DIV`, default 12500: clk cycles per sample tick (1 ms at 12.5 MHz); legal range ≥1.
- `DEB_TICKS`, default 20: consecutive identical samples required to accept a level change; range 1..255.
- `LONG_TICKS`, default 1000: ticks held in the pressed state before a long-press event; range 1..65535.

- `clk`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `key_n`  in  4  raw key inputs, active-low (0 = pressed), asynchronous to clk.
- `key_level`  out  4  debounced state, 1 = pressed.
- `key_press`  out  4  one-cycle pulse per key on accepted press.
- `key_release`  out  4  one-cycle pulse per key on accepted release.
- `key_valid`  out  1  one-cycle pulse when any `key_press` bit fires.
- `key_code`  out  2  index of the last pressed key; held between events.
- `key_long`  out  4  one-cycle long-press pulse per key; constant 0 when the feature is compiled out.

## Operation
- **Synchroniser:** 2-flop synchroniser per bit, then inversion gives `key_s[i]`, where 1 = pressed. Reset value is 0, meaning released.
- **Tick generator:**
  - Down-counter, reset to TICK_DIV-1.
  - When it reaches 0, `tick` is asserted for one cycle and the counter reloads to TICK_DIV-1.
  - With TICK_DIV=1, `tick` is high every cycle.
- **Per-key FSM** (states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT). The FSM evaluates only on `tick` cycles and holds otherwise. Each key has an 8-bit count `cnt`.
  - IDLE:
    - `key_s`=1 → PRESS_WAIT with `cnt`=1.
    - If DEB_TICKS=1, go directly to PRESSED with the press event.
  - PRESS_WAIT:
    - `key_s`=1 → `cnt`+1. When `cnt`+1 = DEB_TICKS → PRESSED: set `key_level`, pulse `key_press`.
    - `key_s`=0 → IDLE with `cnt`=0 (bounce rejected, no event).
  - PRESSED: `key_s`=0 → RELEASE_WAIT with `cnt`=1 (or a direct release if DEB_TICKS=1).
  - RELEASE_WAIT:
    - `key_s`=0 → `cnt`+1. When it reaches DEB_TICKS → IDLE: clear `key_level`, pulse `key_release`.
    - `key_s`=1 → PRESSED with `cnt`=0 (no event).
- **Key encoder:**
  - When any `key_press` bit fires, `key_valid` pulses in the same cycle.
  - `key_code` takes the lowest set index; simultaneous presses on keys 1 and 3 give `key_code`=1.
  - The other simultaneous presses still appear on `key_press` but not in `key_code`.
- **Keys are independent:** any combination of keys may be held at once.

## Timing
- **Reset values:** all outputs 0; all FSMs IDLE; all `cnt` 0; tick counter TICK_DIV-1.
- **Reset mid-operation:** all state is discarded immediately.
  - A key held through reset is treated as a new press after reset.
  - That press produces `key_press` after full debounce.
- **Input latency:** 2 clk of synchronisation before a change is visible on `key_s`.
- **Event latency:** `key_press`, `key_release`, `key_valid`, `key_long` and `key_level` change on the clk edge that ends the qualifying tick cycle. They are visible in the cycle after that tick.
- **Pulse width:** every pulse is exactly one clk wide. At most one press and one release per key per acceptance.
- **Minimum debounce time:** DEB_TICKS ticks. Worst case is DEB_TICKS×TICK_DIV + TICK_DIV + 2 clk after the input settles.
- **Counter saturation:** `cnt` never exceeds DEB_TICKS.

## Configuration
- Macro: `KEY4_LONGPRESS_EN`.
- **Defined:**
  - Each key has a 16-bit `lcnt`, cleared on entry to PRESSED. It increments on each tick while in PRESSED or RELEASE_WAIT.
  - When `lcnt` reaches LONG_TICKS, `key_long[i]` pulses once and `lcnt` saturates. There are no repeats until the key is released (IDLE).
  - `lcnt` is not cleared by a rejected release bounce.
- **Undefined:** `key_long` is tied to 4'b0000, with no long counters in the design. All other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10.
1. Reset with `key_n`=4'hF, run 100 clk → all outputs stay 0; `tick` period is exactly 4 clk.
2. Drive `key_n[2]` low and hold → exactly one `key_press`=4'b0100 and `key_valid`=1 with `key_code`=2. This comes after the 3rd pressed tick sample, within 3×4+4+2 clk. `key_level[2]`=1 afterwards.
3. Bounce key 0 (low 5 clk, high 5 clk, repeated 4 times), then release → no `key_press` and `key_level[0]` stays 0. Then hold low 20 clk → exactly one press.
4. Press keys 1 and 3 on the same clk → `key_press`=4'b1010 in one cycle, `key_code`=1, single `key_valid`. Release both → `key_release`=4'b1010 once.
5. Hold key 0 pressed through assertion of nrst mid-PRESS_WAIT → outputs go to 0 immediately. After deassertion, the press is re-debounced and `key_press[0]` fires once.
6. With `KEY4_LONGPRESS_EN`: hold key 3 for 60 clk → `key_long[3]` pulses once, 10 ticks after `key_press[3]`, with no repeat. Without the macro, `key_long` stays 0.

Source files
------------

// File: rtl/key4_debounce.sv
// key4_debounce: four active-low key inputs -> synchronised, tick-debounced levels, press/release pulses, key code.
// Define KEY4_LONGPRESS_EN to build the per-key long-press detector; otherwise key_long is tied low.
module key4_debounce #(
    parameter int TICK_DIV   = 12500,
    parameter int DEB_TICKS  = 20,
    parameter int LONG_TICKS = 1000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic [3:0] key_long
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [7:0] DEB = 8'(DEB_TICKS);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [3:0]    sync1, sync2, key_s, press_d, release_d;
    logic [TW-1:0] tcnt;
    logic          tick;

    // synchroniser flops reset to "released" so a held key looks like a fresh press after reset
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) {sync2, sync1} <= 8'hFF;
        else {sync2, sync1} <= {sync1, key_n};

    assign key_s = ~sync2;

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) tcnt <= TICK_MAX;
        else tcnt <= tick ? TICK_MAX : tcnt - TW'(1);

    assign tick = tcnt == '0;

    for (genvar i = 0; i < 4; i++) begin : g
        state_t     st, st_nxt;
        logic [7:0] cnt, cnt_nxt;
        logic       p, r;

        always_ff @(posedge clk or negedge nrst)
            if (!nrst) begin
                st  <= IDLE;
                cnt <= 8'd0;
            end else begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
            end

        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            if (tick)
                case (st)
                    IDLE:
                        if (key_s[i]) begin
                            st_nxt  = DEB == 8'd1 ? PRESSED : PRESS_WAIT;
                            cnt_nxt = DEB == 8'd1 ? 8'd0 : 8'd1;
                        end
                    PRESS_WAIT:
                        if (key_s[i]) begin
                            st_nxt  = cnt + 8'd1 == DEB ? PRESSED : PRESS_WAIT;
                            cnt_nxt = cnt + 8'd1 == DEB ? 8'd0 : cnt + 8'd1;
                        end else begin
                            st_nxt  = IDLE;
                            cnt_nxt = 8'd0;
                        end
                    PRESSED:
                        if (!key_s[i]) begin
                            st_nxt  = DEB == 8'd1 ? IDLE : RELEASE_WAIT;
                            cnt_nxt = DEB == 8'd1 ? 8'd0 : 8'd1;
                        end
                    RELEASE_WAIT:
                        if (!key_s[i]) begin
                            st_nxt  = cnt + 8'd1 == DEB ? IDLE : RELEASE_WAIT;
                            cnt_nxt = cnt + 8'd1 == DEB ? 8'd0 : cnt + 8'd1;
                        end else begin
                            st_nxt  = PRESSED;
                            cnt_nxt = 8'd0;
                        end
                endcase
        end

        always_comb begin
            p = tick && key_s[i] && ((st == IDLE && DEB == 8'd1) || (st == PRESS_WAIT && cnt + 8'd1 == DEB));
            r = tick && !key_s[i] && ((st == PRESSED && DEB == 8'd1) || (st == RELEASE_WAIT && cnt + 8'd1 == DEB));
        end

        assign press_d[i]   = p;
        assign release_d[i] = r;
        assign key_level[i] = st == PRESSED || st == RELEASE_WAIT;

`ifdef KEY4_LONGPRESS_EN
        localparam logic [15:0] LT = 16'(LONG_TICKS);
        logic [15:0] lcnt;
        logic        held, long_q;

        assign held = st == PRESSED || st == RELEASE_WAIT;

        // lcnt survives a rejected release bounce; only a fresh press clears it
        always_ff @(posedge clk or negedge nrst)
            if (!nrst) begin
                lcnt   <= 16'd0;
                long_q <= 1'b0;
            end else begin
                long_q <= tick && held && lcnt + 16'd1 == LT;
                if (st_nxt == PRESSED && (st == IDLE || st == PRESS_WAIT)) lcnt <= 16'd0;
                else if (tick && held && lcnt != LT) lcnt <= lcnt + 16'd1;
            end

        assign key_long[i] = long_q;
`else
        assign key_long[i] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            key_press   <= 4'd0;
            key_release <= 4'd0;
            key_valid   <= 1'b0;
            key_code    <= 2'd0;
        end else begin
            key_press   <= press_d;
            key_release <= release_d;
            key_valid   <= |press_d;
            if (|press_d) key_code <= press_d[0] ? 2'd0 : press_d[1] ? 2'd1 : press_d[2] ? 2'd2 : 2'd3;
        end
endmodule

// File: tb/tb_key4_debounce.sv
// tb_key4_debounce: directed vectors for key4_debounce with TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10.
// Long-press expectations follow KEY4_LONGPRESS_EN when the bench is built.
module tb_key4_debounce;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_level, key_press, key_release, key_long;
    logic       key_valid;
    logic [1:0] key_code;

    key4_debounce #(.TICK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(10)) dut (
        .clk(clk), .nrst(nrst), .key_n(key_n),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_valid(key_valid), .key_code(key_code), .key_long(key_long)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] kn;
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
        logic [1:0] code;
    } step_t;

    int checks = 0;
    int errors = 0;
    step_t tbl[18];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // hold key_n for cyc clocks, count every pulse cycle, then compare counts and final levels
    task automatic run_step(input int id, input step_t s);
        int pc[4] = '{0, 0, 0, 0};
        int rc[4] = '{0, 0, 0, 0};
        int vc = 0;
        key_n = s.kn;
        repeat (s.cyc) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                pc[i] += int'(key_press[i]);
                rc[i] += int'(key_release[i]);
            end
            vc += int'(key_valid);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("step%0d press_count[%0d]", id, i), pc[i], int'(s.press[i]));
            chk($sformatf("step%0d release_count[%0d]", id, i), rc[i], int'(s.rel[i]));
        end
        chk($sformatf("step%0d valid_count", id), vc, int'(|s.press));
        chk($sformatf("step%0d key_level", id), int'(key_level), int'(s.level));
        chk($sformatf("step%0d key_code", id), int'(key_code), int'(s.code));
    endtask

    initial begin
        int n, last, nt, lc;
        tbl[0]  = '{4'hF, 100, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[1]  = '{4'hE,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[2]  = '{4'hF,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[3]  = '{4'hE,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[4]  = '{4'hF,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[5]  = '{4'hE,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[6]  = '{4'hF,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[7]  = '{4'hE,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[8]  = '{4'hF,   5, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[9]  = '{4'hF,  40, 4'h0, 4'h0, 4'h0, 2'd2};
        tbl[10] = '{4'hE,  20, 4'h1, 4'h0, 4'h1, 2'd0};
        tbl[11] = '{4'hF,  40, 4'h0, 4'h1, 4'h0, 2'd0};
        tbl[12] = '{4'h5,  40, 4'hA, 4'h0, 4'hA, 2'd1};
        tbl[13] = '{4'hF,  40, 4'h0, 4'hA, 4'h0, 2'd1};
        tbl[14] = '{4'hA,  40, 4'h5, 4'h0, 4'h5, 2'd0};
        tbl[15] = '{4'hB,  40, 4'h0, 4'h1, 4'h4, 2'd0};
        tbl[16] = '{4'hF,  40, 4'h0, 4'h4, 4'h0, 2'd0};
        tbl[17] = '{4'h7,  40, 4'h8, 4'h0, 4'h8, 2'd3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({key_level, key_press, key_release, key_valid, key_code, key_long}), 0);
        nrst = 1'b1;

        last = -1;
        nt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dut.tick) begin
                if (last >= 0) chk("tick_period", c - last, 4);
                last = c;
                nt++;
            end
        end
        chk("tick_count_40clk", nt, 10);

        key_n = 4'hB;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (key_press == 4'h0 && n < 18);
        checks++;
        if (n < 11 || n > 18 || key_press == 4'h0) begin
            errors++;
            $display("FAIL press_latency: got %0d clk (press %h), required 11..18", n, key_press);
        end
        chk("k2_press", int'(key_press), 4'h4);
        chk("k2_valid", int'(key_valid), 1);
        chk("k2_code", int'(key_code), 2);
        @(posedge clk); #1;
        chk("k2_press_width", int'(key_press), 0);
        chk("k2_valid_width", int'(key_valid), 0);
        chk("k2_level", int'(key_level), 4'h4);
        run_step(100, '{4'hF, 40, 4'h0, 4'h4, 4'h0, 2'd2});

        for (int k = 0; k < 18; k++) run_step(k, tbl[k]);

        key_n = 4'h6;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_level", int'(key_level), 4'h8);
        nrst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({key_level, key_press, key_release, key_valid, key_code, key_long}), 0);
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        run_step(101, '{4'h6, 40, 4'h9, 4'h0, 4'h9, 2'd0});
        run_step(102, '{4'hF, 40, 4'h0, 4'h9, 4'h0, 2'd0});

        key_n = 4'h7;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!key_press[3] && n < 30);
        chk("k3_press_seen", int'(key_press[3]), 1);
        lc = 0;
`ifdef KEY4_LONGPRESS_EN
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!key_long[3] && n < 60);
        chk("long_delay_clk", n, 40);
        chk("long_mask", int'(key_long), 4'h8);
        repeat (20) begin
            @(posedge clk); #1;
            lc += int'(key_long[3]);
        end
        chk("long_repeat", lc, 0);
`else
        repeat (60) begin
            @(posedge clk); #1;
            lc += int'(|key_long);
        end
        chk("long_disabled", lc, 0);
`endif
        run_step(103, '{4'hF, 40, 4'h0, 4'h8, 4'h0, 2'd3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
